pattern_serializer: RTL and testbench

- Parametrised successor to the fixed 8-entry, 8-bit pattern-memory / 3-bit-counter / 8:1-mux serializer.
- Holds DEPTH writable patterns of WIDTH bits each. A pattern is chosen by `sel` and shifted out one bit per enabled clock on `outp`.
- Adds what the fixed version lacks: start/busy/done handshake, one-shot or looping frames, selectable bit order, runtime pattern writes, and a hold on `en` low.
- Sits between the control logic and the serial line driver.

---
 rtl/pattern_serializer_pkg.sv | 26 ++
 rtl/pattern_mem.sv | 41 ++++
 rtl/pattern_serializer.sv | 151 +++++++++++++++
 tb/tb_pattern_serializer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pattern_serializer_pkg.sv
// pattern_serializer_pkg: shared types and constants for the pattern serializer.
//   - state_e / ST_* : FSM state encoding (IDLE, SHIFT, PAR)
//   - DEF_WIDTH, DEF_DEPTH : default pattern width and memory depth
//   - reset_pattern(k) : power-on / clear contents of pattern memory entry k
package pattern_serializer_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_e;

    // Plain vector constants so state registers stay simple logic vectors.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;

    // Entry k resets to k; callers truncate/zero-extend to their WIDTH.
    function automatic logic [63:0] reset_pattern(input int unsigned k);
        return 64'(k);
    endfunction

endpackage

// File: rtl/pattern_mem.sv
// pattern_mem: DEPTH x WIDTH pattern register file.
// Ports:
//   i_clk      clock (rising edge)
//   i_clr      synchronous active-high clear; entry k reloads to k
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  combinational read address
//   o_rd_data  read data (pre-write contents when read and write collide)
module pattern_mem
    import pattern_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned SEL_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  logic [SEL_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [SEL_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_mem[k] <= WIDTH'(reset_pattern(k));
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read straight from the registers: a same-cycle write is not yet visible.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pattern_serializer.sv
// pattern_serializer: shifts a stored WIDTH-bit pattern out one bit per enabled clock.
// Optional feature macro: PATTERN_SERIALIZER_PARITY_EN (appends an even-parity bit).
// Ports:
//   i_clk        clock (rising edge)
//   i_clr        synchronous active-high reset, highest priority
//   i_en         advance enable; low freezes the frame in progress
//   i_sel        pattern select, sampled at frame start and loop wrap
//   i_start      frame request (pulse or level)
//   i_mode_loop  1 = repeat frames back to back, 0 = one-shot
//   i_msb_first  bit order, sampled with i_sel
//   i_wr_en      pattern write strobe
//   i_wr_addr    pattern write address
//   i_wr_data    pattern write data
//   o_outp       serial data bit (registered)
//   o_bit_idx    index of the bit currently on o_outp
//   o_busy       frame in progress
//   o_done       high while the final bit of a one-shot frame is on o_outp
module pattern_serializer
    import pattern_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned SEL_W = $clog2(DEPTH),
    localparam int unsigned IDX_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_start,
    input  logic             i_mode_loop,
    input  logic             i_msb_first,
    input  logic             i_wr_en,
    input  logic [SEL_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_outp,
    output logic [IDX_W-1:0] o_bit_idx,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(WIDTH - 1);

`ifdef PATTERN_SERIALIZER_PARITY_EN
    localparam logic [1:0]       ST_FINAL = ST_PAR;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH);
`else
    localparam logic [1:0]       ST_FINAL = ST_SHIFT;
    localparam logic [IDX_W-1:0] LAST_IDX = LAST_DATA;
`endif

    logic [1:0]       r_state, w_state_d;
    logic [WIDTH-1:0] r_word, w_word_d;
    logic             r_order, w_order_d;
    logic [IDX_W-1:0] r_idx, w_idx_d;
    logic             r_outp, w_outp_d;

    logic [WIDTH-1:0] w_rd_data;
    logic [WIDTH-1:0] w_shr;
    logic [IDX_W-1:0] w_nxt_idx;
    logic [IDX_W-1:0] w_pos;
    logic             w_shift_bit;
    logic             w_first_bit;
    logic             w_at_end;
    logic             w_frame_end;
    logic             w_load;

    pattern_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk     (i_clk),
        .i_clr     (i_clr),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (i_sel),
        .o_rd_data (w_rd_data)
    );

    // Next data bit: position counted from the MSB or the LSB depending on latched order.
    assign w_nxt_idx   = r_idx + IDX_W'(1);
    assign w_pos       = r_order ? (LAST_DATA - w_nxt_idx) : w_nxt_idx;
    assign w_shr       = r_word >> w_pos;
    assign w_shift_bit = w_shr[0];
    assign w_first_bit = i_msb_first ? w_rd_data[WIDTH-1] : w_rd_data[0];

    // Final bit of the frame is on o_outp; the loop/stop decision is taken here.
    assign w_at_end    = (r_state == ST_FINAL) && (r_idx == LAST_IDX);
    assign w_frame_end = w_at_end && i_en;
    assign w_load      = i_en && (((r_state == ST_IDLE) && i_start) ||
                                  (w_frame_end && i_mode_loop));

    always_comb begin
        w_state_d = r_state;
        w_word_d  = r_word;
        w_order_d = r_order;
        w_idx_d   = r_idx;
        w_outp_d  = r_outp;

        if ((r_state == ST_SHIFT) && i_en && (r_idx != LAST_DATA)) begin
            w_idx_d  = w_nxt_idx;
            w_outp_d = w_shift_bit;
        end

`ifdef PATTERN_SERIALIZER_PARITY_EN
        if ((r_state == ST_SHIFT) && i_en && (r_idx == LAST_DATA)) begin
            w_state_d = ST_PAR;
            w_idx_d   = IDX_W'(WIDTH);
            w_outp_d  = ^r_word;
        end
`endif

        if (w_frame_end && !i_mode_loop) begin
            w_state_d = ST_IDLE;
            w_idx_d   = '0;
            w_outp_d  = 1'b0;
        end

        // Covers both a fresh start and a seamless loop wrap.
        if (w_load) begin
            w_state_d = ST_SHIFT;
            w_word_d  = w_rd_data;
            w_order_d = i_msb_first;
            w_idx_d   = '0;
            w_outp_d  = w_first_bit;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_order <= 1'b0;
            r_idx   <= '0;
            r_outp  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_word  <= w_word_d;
            r_order <= w_order_d;
            r_idx   <= w_idx_d;
            r_outp  <= w_outp_d;
        end
    end

    assign o_outp    = r_outp;
    assign o_bit_idx = r_idx;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_done    = w_at_end && !i_mode_loop;

endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer: scoreboard bench for pattern_serializer (WIDTH=8, DEPTH=8).
// Honours PATTERN_SERIALIZER_PARITY_EN to expect the trailing parity bit.
module tb_pattern_serializer;

    localparam int unsigned SEL_W = 3;
    localparam int unsigned IDX_W = 4;
`ifdef PATTERN_SERIALIZER_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    typedef struct packed {
        logic             outp;
        logic [IDX_W-1:0] idx;
        logic             done;
    } exp_t;

    logic             clk = 1'b0;
    logic             clr, en, start, mode_loop, msb_first, wr_en;
    logic [SEL_W-1:0] sel, wr_addr;
    logic [7:0]       wr_data;
    logic             outp, busy, done;
    logic [IDX_W-1:0] bit_idx;

    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pattern_serializer #(
        .WIDTH (8),
        .DEPTH (8)
    ) dut (
        .i_clk       (clk),
        .i_clr       (clr),
        .i_en        (en),
        .i_sel       (sel),
        .i_start     (start),
        .i_mode_loop (mode_loop),
        .i_msb_first (msb_first),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .o_outp      (outp),
        .o_bit_idx   (bit_idx),
        .o_busy      (busy),
        .o_done      (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected bit stream of one frame; bit stall_at is shown 1+stall_n times.
    task automatic push_frame(input logic [7:0] pat, input logic msb, input logic last_done,
                              input int stall_at, input int stall_n);
        exp_t e;
        for (int i = 0; i < NBITS; i++) begin
            if (i == 8) e.outp = ^pat;
            else        e.outp = msb ? pat[7-i] : pat[i];
            e.idx  = IDX_W'(i);
            e.done = last_done && (i == NBITS - 1);
            for (int r = 0; r < ((i == stall_at) ? 1 + stall_n : 1); r++) sb.push_back(e);
        end
    endtask

    task automatic start_frame(input logic [SEL_W-1:0] s, input logic msb, input logic loop);
        sel       = s;
        msb_first = msb;
        mode_loop = loop;
        en        = 1'b1;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
        check_eq({tag, "_drain"}, 32'(sb.size()), 32'd0);
        check_eq({tag, "_outp0"}, 32'(outp), 32'd0);
        check_eq({tag, "_idx0"}, 32'(bit_idx), 32'd0);
    endtask

    // Scoreboard: every busy cycle consumes one expected bit.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("outp", 32'(outp), 32'(e.outp));
                check_eq("bit_idx", 32'(bit_idx), 32'(e.idx));
                check_eq("done", 32'(done), 32'(e.done));
            end
        end
    end

    initial begin
        clr = 1'b1; en = 1'b0; start = 1'b0; mode_loop = 1'b0; msb_first = 1'b0;
        wr_en = 1'b0; sel = '0; wr_addr = '0; wr_data = '0;
        step();
        step();
        clr = 1'b0;
        check_eq("rst_outp", 32'(outp), 32'd0);
        check_eq("rst_idx", 32'(bit_idx), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);

        // start with en low is ignored
        sel = 3'd3; start = 1'b1; en = 1'b0;
        step();
        start = 1'b0;
        check_eq("start_no_en", 32'(busy), 32'd0);

        // default pattern 3, MSB first
        push_frame(8'h03, 1'b1, 1'b1, -1, 0);
        start_frame(3'd3, 1'b1, 1'b0);
        wait_idle("dflt", 40);

        // write then LSB first
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        push_frame(8'hA5, 1'b0, 1'b1, -1, 0);
        start_frame(3'd5, 1'b0, 1'b0);
        wait_idle("wr_lsb", 40);

        // enable stall at bit 4 for 3 cycles
        push_frame(8'hA5, 1'b0, 1'b1, 4, 3);
        start_frame(3'd5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) step();
        en = 1'b1;
        wait_idle("stall", 40);

        // loop: sel switches mid-frame, loop cleared during the second frame
        push_frame(8'hA5, 1'b0, 1'b0, -1, 0);
        push_frame(8'h03, 1'b0, 1'b1, -1, 0);
        start_frame(3'd5, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step();
        sel = 3'd3;
        for (int i = 0; i < NBITS - 1; i++) step();
        mode_loop = 1'b0;
        wait_idle("loop", 40);

        // abort with clr at bit_idx 2
        push_frame(8'hA5, 1'b1, 1'b1, -1, 0);
        start_frame(3'd5, 1'b1, 1'b0);
        step();
        step();
        check_eq("abort_at2", 32'(bit_idx), 32'd2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_eq("abort_outp", 32'(outp), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_idx", 32'(bit_idx), 32'd0);
        check_eq("abort_left", 32'(sb.size()), 32'(NBITS - 3));
        sb.delete();

        // write collides with latch of the same entry: old data goes out
        push_frame(8'h02, 1'b0, 1'b1, -1, 0);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hFF;
        start_frame(3'd2, 1'b0, 1'b0);
        wr_en = 1'b0;
        wait_idle("collide", 40);
        push_frame(8'hFF, 1'b0, 1'b1, -1, 0);
        start_frame(3'd2, 1'b0, 1'b0);
        wait_idle("after_wr", 40);

`ifdef PATTERN_SERIALIZER_PARITY_EN
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h07;
        step();
        wr_en = 1'b0;
        push_frame(8'h07, 1'b1, 1'b1, -1, 0);
        start_frame(3'd1, 1'b1, 1'b0);
        wait_idle("par07", 40);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
